sram_ctrl: RTL

//  Responder side of the MEM-stage data-memory interface. Accepts a 32-bit read/write

---
 rtl/sram_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage data-memory responder. Each 32-bit request is carried out
// as two halfword accesses (low half, then high half) on an asynchronous SRAM.
// ready doubles as the pipeline's ~freeze signal.
module sram_ctrl #(
   parameter int unsigned BASE_ADDR    = 1024,
   parameter int unsigned SRAM_AW      = 18,
   parameter int unsigned PHASE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   inout  wire  [15:0]        SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);
   // With a single-cycle phase the only cycle is the address-hold cycle, so no WE_N pulse
   localparam bit MULTI = (PHASE_CYCLES > 1);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_wr;
   logic [SRAM_AW-2:0] lat_word;
   logic [15:0]        wd_hi;
   logic [15:0]        dq_out;
   logic               dq_drive;

   logic [31:0]        off;
   logic [SRAM_AW-2:0] word;
   logic [CW-1:0]      cnt_nxt;
   logic               ph_last;
   logic               unused_off;

   assign off        = address - 32'(BASE_ADDR);
   assign word       = off[SRAM_AW:2];
   assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
   assign cnt_nxt    = cnt + 1'b1;
   assign ph_last    = (cnt == LAST);

   assign SRAM_DQ   = dq_drive ? dq_out : 'z;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   // ready: combinational on the request only while idle
   always_comb begin
      ready = 1'b0;
      case (state)
         S_IDLE:  ready = ~(wr_en | rd_en);
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Access sequencer; SRAM strobes are set one edge ahead so they are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         lat_word  <= '0;
         wd_hi     <= '0;
         dq_out    <= '0;
         dq_drive  <= 1'b0;
         read_data <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (wr_en | rd_en) begin
                  op_wr     <= wr_en;
                  lat_word  <= word;
                  wd_hi     <= write_data[31:16];
                  dq_out    <= write_data[15:0];
                  dq_drive  <= wr_en;
                  cnt       <= '0;
                  SRAM_ADDR <= {word, 1'b0};
                  SRAM_WE_N <= ~(wr_en & MULTI);
                  SRAM_OE_N <= wr_en;
                  state     <= S_LO;
               end
            end
            S_LO: begin
               if (ph_last) begin
                  if (!op_wr) read_data[15:0] <= SRAM_DQ;
                  cnt       <= '0;
                  dq_out    <= wd_hi;
                  SRAM_ADDR <= {lat_word, 1'b1};
                  SRAM_WE_N <= ~(op_wr & MULTI);
                  state     <= S_HI;
               end else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == LAST) SRAM_WE_N <= 1'b1;
               end
            end
            S_HI: begin
               if (ph_last) begin
                  if (!op_wr) read_data[31:16] <= SRAM_DQ;
                  cnt       <= '0;
                  dq_drive  <= 1'b0;
                  SRAM_WE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == LAST) SRAM_WE_N <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
